// File: rtl/sync_bus_rx_fifo_if.sv
// sync_bus_rx_fifo_if: capture, consumer handshake and status signals of the rx FIFO
interface sync_bus_rx_fifo_if #(
  parameter int BUS_WIDTH      = 8,
  parameter int DEPTH          = 4,
  parameter int DROP_CNT_WIDTH = 8
);
  logic [BUS_WIDTH-1:0]      sync_bus;
  logic                      enable_pulse;
  logic                      rd_ready;
  logic                      rd_valid;
  logic [BUS_WIDTH-1:0]      rd_data;
  logic                      full;
  logic                      empty;
  logic [$clog2(DEPTH):0]    count;
  logic                      clr_overflow;
  logic                      overflow;
  logic [DROP_CNT_WIDTH-1:0] drop_count;
  modport master (
    output sync_bus, enable_pulse, rd_ready, clr_overflow,
    input  rd_valid, rd_data, full, empty, count, overflow, drop_count
  );
  modport slave (
    input  sync_bus, enable_pulse, rd_ready, clr_overflow,
    output rd_valid, rd_data, full, empty, count, overflow, drop_count
  );
endinterface

// File: rtl/sync_bus_rx_fifo.sv
// sync_bus_rx_fifo: first-word-fall-through buffer for synchronized bus words with overflow tracking
module sync_bus_rx_fifo #(
  parameter int BUS_WIDTH      = 8,
  parameter int DEPTH          = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input logic CLK,
  input logic RST,
  sync_bus_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [BUS_WIDTH-1:0]      mem [DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [AW:0]               count;
  logic                      overflow;
  logic [DROP_CNT_WIDTH-1:0] drop_count;
  logic                      rd, wr, drop;
  // a pop frees a slot in the same cycle, so a full FIFO still accepts a word alongside it
  always_comb begin
    rd   = (count != '0) && bus.rd_ready;
    wr   = bus.enable_pulse && ((count != FULL_CNT) || rd);
    drop = bus.enable_pulse && (count == FULL_CNT) && !rd;
  end
  always_ff @(posedge CLK)
    if (!RST && wr) mem[wr_ptr] <= bus.sync_bus;
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= (wr && !rd) ? count + (AW+1)'(1) : (rd && !wr) ? count - (AW+1)'(1) : count;
      if (bus.clr_overflow) begin
        overflow   <= drop;
        drop_count <= drop ? DROP_CNT_WIDTH'(1) : '0;
      end else if (drop) begin
        overflow   <= 1'b1;
        drop_count <= (&drop_count) ? drop_count : drop_count + DROP_CNT_WIDTH'(1);
      end
    end
  end
  assign bus.rd_valid   = (count != '0);
  assign bus.empty      = (count == '0);
  assign bus.full       = (count == FULL_CNT);
  assign bus.count      = count;
  assign bus.rd_data    = mem[rd_ptr];
  assign bus.overflow   = overflow;
  assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_sync_bus_rx_fifo.sv
// tb_sync_bus_rx_fifo: directed scenarios plus randomized traffic against a queue-based model
module tb_sync_bus_rx_fifo;
  localparam int BW = 8, DEPTH = 4, DCW = 8;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  bit m_ovf;
  int m_dc;
  sync_bus_rx_fifo_if #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)) bus();
  sync_bus_rx_fifo #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;

  // drive one cycle from a negedge, advance the model at the posedge, return at the next negedge
  task automatic step(input logic r, input logic en, input logic [7:0] d, input logic rdy, input logic clr);
    bit pop, drp;
    rst = r; bus.enable_pulse = en; bus.sync_bus = d; bus.rd_ready = rdy; bus.clr_overflow = clr;
    @(posedge clk);
    if (r) begin
      q.delete(); m_ovf = 0; m_dc = 0;
    end else begin
      pop = q.size() > 0 && rdy;
      drp = en && q.size() == DEPTH && !pop;
      if (pop) void'(q.pop_front());
      if (en && !drp) q.push_back(d);
      if (clr) begin m_ovf = drp; m_dc = drp ? 1 : 0; end
      else if (drp) begin m_ovf = 1; if (m_dc < 255) m_dc++; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got %0d want 0", bus.drop_count); end
  endtask

  task automatic test_single;
    step(0, 1, 8'hA5, 0, 0);
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", bus.rd_data); end
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", bus.count); end
    step(0, 0, 0, 1, 0);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b want 0", bus.rd_valid); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", bus.count); end
    step(0, 0, 0, 1, 0);
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL empty_pop_count got %0d want 0", bus.count); end
  endtask

  task automatic test_fill_wrap;
    logic [7:0] exp [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    for (int i = 1; i <= 4; i++) step(0, 1, 8'(i), 0, 0);
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", bus.full); end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", bus.count); end
    step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
    step(0, 1, 8'h05, 0, 0); step(0, 1, 8'h06, 0, 0);
    for (int k = 2; k < 6; k++) begin
      checks++; if (bus.rd_data !== exp[k] || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL wrap_drain[%0d] got %h/%b want %h/1", k, bus.rd_data, bus.rd_valid, exp[k]); end
      step(0, 0, 0, 1, 0);
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) step(0, 1, 8'h20 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h30 + 8'(i), 0, 0);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    checks++; if (bus.drop_count !== 8'd3) begin errors++; $display("FAIL ovf_drop_count got %0d want 3", bus.drop_count); end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", bus.count); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.rd_data !== 8'h20 + 8'(k)) begin errors++; $display("FAIL ovf_drain[%0d] got %h want %h", k, bus.rd_data, 8'h20 + 8'(k)); end
      step(0, 0, 0, 1, 0);
    end
    step(0, 0, 0, 0, 1);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_flag got %b want 0", bus.overflow); end
    checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL clr_drop_count got %0d want 0", bus.drop_count); end
    for (int i = 0; i < 4; i++) step(0, 1, 8'h40, 0, 0);
    step(0, 1, 8'h41, 0, 0); step(0, 1, 8'h42, 0, 1);
    checks++; if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd1) begin errors++; $display("FAIL clr_with_drop got %b/%0d want 1/1", bus.overflow, bus.drop_count); end
    for (int i = 0; i < 260; i++) step(0, 1, 8'h43, 0, 0);
    checks++; if (bus.drop_count !== 8'hFF) begin errors++; $display("FAIL drop_saturate got %0d want 255", bus.drop_count); end
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) step(0, 1, 8'h10 + 8'(i), 0, 0);
    step(0, 1, 8'h14, 1, 0);
    checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1) begin errors++; $display("FAIL b2b_count got %0d/%b want 4/1", bus.count, bus.full); end
    checks++; if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin errors++; $display("FAIL b2b_no_drop got %b/%0d want 0/0", bus.overflow, bus.drop_count); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (bus.rd_data !== 8'h10 + 8'(k)) begin errors++; $display("FAIL b2b_drain[%0d] got %h want %h", k, bus.rd_data, 8'h10 + 8'(k)); end
      step(0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) step(0, 1, 8'h50 + 8'(i), 0, 0);
    step(0, 0, 0, 1, 0);
    checks++; if (bus.count !== 3'd3 || bus.overflow !== 1'b1) begin errors++; $display("FAIL mid_setup got %0d/%b want 3/1", bus.count, bus.overflow); end
    step(1, 0, 0, 0, 0);
    checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL mid_rst_count got %0d/%b want 0/1", bus.count, bus.empty); end
    checks++; if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin errors++; $display("FAIL mid_rst_ovf got %b/%0d want 0/0", bus.overflow, bus.drop_count); end
    step(0, 1, 8'h3C, 0, 0);
    checks++; if (bus.rd_data !== 8'h3C || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL mid_readback got %h/%b want 3c/1", bus.rd_data, bus.rd_valid); end
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(99) == 0, $urandom_range(1), 8'($urandom), $urandom_range(9) < 4, $urandom_range(19) == 0);
      checks++; if (int'(bus.count) !== q.size()) begin errors++; $display("FAIL rand_count@%0d got %0d want %0d", n, bus.count, q.size()); end
      checks++; if (bus.rd_valid !== (q.size() > 0) || bus.full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rand_flags@%0d got v%b f%b want size %0d", n, bus.rd_valid, bus.full, q.size()); end
      if (q.size() > 0) begin
        checks++; if (bus.rd_data !== q[0]) begin errors++; $display("FAIL rand_data@%0d got %h want %h", n, bus.rd_data, q[0]); end
      end
      checks++; if (bus.overflow !== m_ovf || int'(bus.drop_count) !== m_dc) begin errors++; $display("FAIL rand_ovf@%0d got %b/%0d want %b/%0d", n, bus.overflow, bus.drop_count, m_ovf, m_dc); end
    end
  endtask

  initial begin
    bus.enable_pulse = 0; bus.sync_bus = 0; bus.rd_ready = 0; bus.clr_overflow = 0;
    @(negedge clk);
    test_reset;
    test_single;
    test_fill_wrap;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
